imem_port_arbiter: RTL and testbench

//  Owns the single synchronous instruction-memory port and shares it among three requesters:
//   - boot loader writes, allowed only while booting;
//   - MEM-stage loads from the instruction region (constants / self-inspection);
//   - IF-stage fetch.

---
 rtl/imem_port_arbiter_pkg.sv | 19 +
 rtl/imem_grant_logic.sv | 23 ++
 rtl/imem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared encodings for the instruction-memory port arbiter.
//   State encoding : ST_BOOT / ST_RUN
//   Owner encoding : OWN_NONE / OWN_LD / OWN_FETCH (who gets rom_rdata next cycle)
//   NOP_INSTR      : instruction presented to IF when no valid fetch is returned
package imem_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_LD    = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;

    // addi x0, x0, 0
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_grant_logic.sv
// Combinational read-grant priority for the instruction-memory port.
//   run_i          : arbiter is in RUN (reads allowed)
//   ld_req_i       : MEM-stage load request
//   fetch_req_i    : IF fetch request
//   force_fetch_i  : fairness override, fetch beats ld for this grant
//   ld_grant_o     : load owns the port this cycle
//   fetch_grant_o  : fetch owns the port this cycle
module imem_grant_logic (
    input  logic run_i,
    input  logic ld_req_i,
    input  logic fetch_req_i,
    input  logic force_fetch_i,
    output logic ld_grant_o,
    output logic fetch_grant_o
);

    // Loads normally win; a starved fetch takes the port when forced.
    always_comb begin
        ld_grant_o    = run_i & ld_req_i & ~(force_fetch_i & fetch_req_i);
        fetch_grant_o = run_i & fetch_req_i & ~ld_grant_o;
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous instruction-memory port between the boot
// loader (writes, BOOT only), MEM-stage loads and IF fetch (reads, RUN only).
// Grant and port drive are combinational; read data is steered to the
// registered owner one cycle later.
// Optional feature: define IMEM_ARB_FAIR_EN to add a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive denied fetch cycles.
// Ports:
//   clk, rst                       clock, async active-high reset
//   boot_done                      loader finished (sampled in BOOT)
//   wr_req/wr_addr/wr_data/wr_ack  loader write channel
//   ld_req/ld_addr/ld_data/ld_valid MEM-stage read channel
//   fetch_req/fetch_addr/fetch_instr/fetch_valid IF read channel
//   PL_stall_arb                   IF must hold pc this cycle
//   PL_flush                       squash the fetch granted this cycle
//   rom_en/rom_we/rom_addr/rom_wdata/rom_rdata memory port
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_valid,
    output logic              PL_stall_arb,
    input  logic              PL_flush,
    output logic              rom_en,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_wdata,
    input  logic [DATA_W-1:0] rom_rdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [0:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              ld_grant;
    logic              fetch_grant;
    logic              force_fetch;
    logic [ADDR_W-1:0] sel_addr;

    imem_grant_logic u_grant (
        .run_i         (state_q == ST_RUN),
        .ld_req_i      (ld_req),
        .fetch_req_i   (fetch_req),
        .force_fetch_i (force_fetch),
        .ld_grant_o    (ld_grant),
        .fetch_grant_o (fetch_grant)
    );

`ifdef IMEM_ARB_FAIR_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign force_fetch = (starve_q == STARVE_W'(STARVE_MAX));

    // Count RUN cycles in which a requesting fetch lost the port.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_RUN) begin
            if (fetch_grant) begin
                starve_d = '0;
            end else if (fetch_req && !force_fetch) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve;

    assign force_fetch   = 1'b0;
    assign unused_starve = (STARVE_MAX == 0);
`endif

    // Next state, port drive and response ownership.
    always_comb begin
        state_d   = state_q;
        owner_d   = OWN_NONE;
        rom_en    = 1'b0;
        rom_we    = 1'b0;
        rom_wdata = '0;
        sel_addr  = '0;
        wr_ack    = 1'b0;

        if (state_q == ST_BOOT) begin
            if (wr_req) begin
                rom_en    = 1'b1;
                rom_we    = 1'b1;
                rom_wdata = wr_data;
                sel_addr  = wr_addr;
                wr_ack    = 1'b1;
            end else if (boot_done) begin
                state_d = ST_RUN;
            end
        end else begin
            if (ld_grant) begin
                rom_en   = 1'b1;
                sel_addr = ld_addr;
                owner_d  = OWN_LD;
            end else if (fetch_grant) begin
                rom_en   = 1'b1;
                sel_addr = fetch_addr;
                // A flushed fetch still uses the port but its data is dropped.
                owner_d  = PL_flush ? OWN_NONE : OWN_FETCH;
            end
        end
    end

    assign rom_addr     = sel_addr & ALIGN_MASK;
    assign PL_stall_arb = (state_q == ST_BOOT) | (fetch_req & ~fetch_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Steer the memory response to whoever owned the port last cycle.
    always_comb begin
        ld_valid    = (owner_q == OWN_LD);
        fetch_valid = (owner_q == OWN_FETCH);
        ld_data     = ld_valid ? rom_rdata : '0;
        fetch_instr = fetch_valid ? rom_rdata : NOP_INSTR;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a behavioural synchronous memory.
module tb_imem_port_arbiter;
    import imem_port_arbiter_pkg::*;

    localparam int unsigned AW = 32;
`ifdef IMEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          boot_done;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_ack;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_valid;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_instr;
    logic          fetch_valid;
    logic          PL_stall_arb;
    logic          PL_flush;
    logic          rom_en;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic [31:0]   rom_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_ld[$];
    logic [31:0] exp_fetch[$];

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .boot_done    (boot_done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .fetch_valid  (fetch_valid),
        .PL_stall_arb (PL_stall_arb),
        .PL_flush     (PL_flush),
        .rom_en       (rom_en),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .rom_rdata    (rom_rdata)
    );

    // Synchronous memory: word at byte address A initially reads 0xC0DE0000|A.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    end

    always @(posedge clk) begin
        if (rom_en && rom_we) mem[rom_addr[9:2]] <= rom_wdata;
        if (rom_en && !rom_we) rom_rdata <= mem[rom_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response the DUT presents must match the next expectation.
    always @(negedge clk) begin
        if (ld_valid) begin
            if (exp_ld.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ld_unexpected: got ld_valid data=%h expected no response at %0t", ld_data, $time);
            end else begin
                check("ld_data", ld_data, exp_ld.pop_front());
            end
        end
        if (fetch_valid) begin
            if (exp_fetch.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: got fetch_valid instr=%h expected no response at %0t", fetch_instr, $time);
            end else begin
                check("fetch_instr", fetch_instr, exp_fetch.pop_front());
            end
        end
    end

    task automatic drained(input string name);
        check({name, "_ld_left"}, 32'(exp_ld.size()), 32'd0);
        check({name, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
    endtask

    task automatic boot_write(input logic [31:0] a, input logic [31:0] d, input logic bd);
        wr_req = 1'b1; wr_addr = a; wr_data = d; boot_done = bd;
        @(negedge clk);
        check("boot_wr_ack", wr_ack, 1'b1);
        check("boot_rom_we", rom_we, 1'b1);
        check("boot_rom_addr", rom_addr, a & ~32'd3);
        next_cycle();
    endtask

    initial begin
        logic fw;
        rst = 1'b1; boot_done = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        ld_req = 1'b0; ld_addr = '0; fetch_req = 1'b0; fetch_addr = '0; PL_flush = 1'b0;

        // Reset state
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_stall", PL_stall_arb, 1'b1);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_ld_valid", ld_valid, 1'b0);
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_fetch_instr", fetch_instr, NOP_INSTR);
        next_cycle();
        rst = 1'b0;

        // T1: write, reset mid-BOOT, three writes with boot_done on the last
        boot_write(32'h100, 32'h1111_0001, 1'b0);
        wr_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t1_rst_stall", PL_stall_arb, 1'b1);
        check("t1_rst_rom_we", rom_we, 1'b0);
        next_cycle();
        rst = 1'b0;
        boot_write(32'h100, 32'hB007_0000, 1'b0);
        boot_write(32'h104, 32'hB007_0001, 1'b0);
        boot_write(32'h10A, 32'hB007_0002, 1'b1);
        wr_req = 1'b0;
        @(negedge clk);
        check("t1_still_boot", PL_stall_arb, 1'b1);
        next_cycle();
        @(negedge clk);
        check("t1_run_stall", PL_stall_arb, 1'b0);
        next_cycle();

        // T2: back-to-back fetches of the words the loader wrote
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch_addr = 32'h100 + 32'(k * 4);
            exp_fetch.push_back(32'hB007_0000 + 32'(k));
            @(negedge clk);
            check("t2_stall", PL_stall_arb, 1'b0);
            check("t2_rom_addr", rom_addr, 32'h100 + 32'(k * 4));
            next_cycle();
        end
        fetch_req = 1'b0;
        next_cycle();
        drained("t2");

        // T3: ld and fetch collide; ld first, fetch next cycle
        ld_req = 1'b1; ld_addr = 32'h40; fetch_req = 1'b1; fetch_addr = 32'h10;
        exp_ld.push_back(32'hC0DE_0040);
        @(negedge clk);
        check("t3_stall_ld", PL_stall_arb, 1'b1);
        check("t3_addr_ld", rom_addr, 32'h40);
        next_cycle();
        ld_req = 1'b0;
        exp_fetch.push_back(32'hC0DE_0010);
        @(negedge clk);
        check("t3_stall_fetch", PL_stall_arb, 1'b0);
        check("t3_addr_fetch", rom_addr, 32'h10);
        next_cycle();
        fetch_req = 1'b0;
        next_cycle();
        drained("t3");

        // T4: flush squashes the fetch granted with it; next fetch normal
        fetch_req = 1'b1; fetch_addr = 32'h20; PL_flush = 1'b1;
        @(negedge clk);
        check("t4_stall", PL_stall_arb, 1'b0);
        next_cycle();
        PL_flush = 1'b0; fetch_addr = 32'h24;
        exp_fetch.push_back(32'hC0DE_0024);
        @(negedge clk);
        check("t4_squash_valid", fetch_valid, 1'b0);
        check("t4_squash_instr", fetch_instr, NOP_INSTR);
        next_cycle();
        fetch_req = 1'b0;
        // ld responses survive a flush
        ld_req = 1'b1; ld_addr = 32'h46; PL_flush = 1'b1;
        exp_ld.push_back(32'hC0DE_0044);
        next_cycle();
        ld_req = 1'b0; PL_flush = 1'b0;
        next_cycle();
        drained("t4");

        // T5: ld held 6 cycles against a held fetch
        ld_req = 1'b1; ld_addr = 32'h48; fetch_req = 1'b1; fetch_addr = 32'h28;
        for (int c = 1; c <= 6; c++) begin
            fw = FAIR && (c == 5);
            if (fw) exp_fetch.push_back(32'hC0DE_0028);
            else    exp_ld.push_back(32'hC0DE_0048);
            @(negedge clk);
            check("t5_stall", PL_stall_arb, fw ? 1'b0 : 1'b1);
            check("t5_addr", rom_addr, fw ? 32'h28 : 32'h48);
            next_cycle();
        end
        ld_req = 1'b0;
        exp_fetch.push_back(32'hC0DE_0028);
        @(negedge clk);
        check("t5_fetch_stall", PL_stall_arb, 1'b0);
        next_cycle();
        fetch_req = 1'b0;
        next_cycle();
        drained("t5");

        // T6: writes ignored in RUN
        wr_req = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t6_wr_ack", wr_ack, 1'b0);
        check("t6_rom_we", rom_we, 1'b0);
        check("t6_rom_en", rom_en, 1'b0);
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 32'h100;
        exp_fetch.push_back(32'hB007_0000);
        @(negedge clk);
        check("t6_rom_we_fetch", rom_we, 1'b0);
        next_cycle();
        wr_req = 1'b0; fetch_req = 1'b0;
        next_cycle();
        drained("t6a");

        // T6: reset while a load is in flight
        ld_req = 1'b1; ld_addr = 32'h4C;
        @(negedge clk);
        check("t6_ld_addr", rom_addr, 32'h4C);
        next_cycle();
        ld_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ld_valid", ld_valid, 1'b0);
        check("t6_rst_stall", PL_stall_arb, 1'b1);
        next_cycle();
        rst = 1'b0;
        boot_write(32'h200, 32'h5A5A_5A5A, 1'b1);
        wr_req = 1'b0;
        next_cycle();
        next_cycle();
        drained("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
